// File: rtl/lvds_pkg.sv
// lvds_pkg: shared types and constants for the LVDS transmit serializer.
// Holds the FSM state enum, word/lane widths and the lane-split helpers.
package lvds_pkg;

  localparam int LANES  = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // odd word bits go out on the rising half
  function automatic logic [LANES-1:0] lane_rise(
    input logic [WORD_W-1:0] w
  );
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[i] = w[2*i+1];
    return r;
  endfunction

  // even word bits go out on the falling half
  function automatic logic [LANES-1:0] lane_fall(
    input logic [WORD_W-1:0] w
  );
    logic [LANES-1:0] f;
    for (int i = 0; i < LANES; i++) f[i] = w[2*i];
    return f;
  endfunction

endpackage

// File: rtl/lvds_tx_fifo.sv
// lvds_tx_fifo: synchronous word buffer in front of the serializer.
// Power-of-two depth so the pointers wrap for free.
module lvds_tx_fifo
  import lvds_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WORD_W-1:0]       din,
  input  logic                    pop,
  output logic [WORD_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lvds_tx_serializer.sv
// lvds_tx_serializer: buffered 16-bit word to 8-lane DDR serializer.
// Optional training bursts enabled by macro LVDS_TX_TRAIN_EN.
module lvds_tx_serializer
  import lvds_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                TRAIN_LEN  = 64,
  parameter logic [WORD_W-1:0] TRAIN_WORD = 16'hA5C3,
  parameter logic [WORD_W-1:0] IDLE_WORD  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              train_req,
  output logic [LANES-1:0]  tx_rise,
  output logic [LANES-1:0]  tx_fall,
  output logic              tx_active,
  output logic              training,
  output logic              underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  state_t            state_q;
  state_t            state_d;
  logic              booted;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic              act_d;
  logic              trn_d;
  logic              und_d;

`ifdef LVDS_TX_TRAIN_EN
  localparam logic [15:0] LAST = 16'(TRAIN_LEN - 1);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        trn_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{train_req, TRAIN_WORD, 16'(TRAIN_LEN), trn_d};
`endif

  assign s_ready = booted && (count != FULL_CNT);
  assign push    = s_valid && s_ready && !full;

  lvds_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // input side opens on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) booted <= 1'b0;
    else        booted <= 1'b1;
  end

  // next state, pop and next output word
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    word_d  = IDLE_WORD;
    act_d   = 1'b0;
    trn_d   = 1'b0;
    und_d   = 1'b0;
`ifdef LVDS_TX_TRAIN_EN
    cnt_d   = cnt_q;
    if (state_q == ST_TRAIN) begin
      word_d = TRAIN_WORD;
      trn_d  = 1'b1;
      if (cnt_q == LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (train_req || !booted) begin
      word_d  = TRAIN_WORD;
      trn_d   = 1'b1;
      cnt_d   = 16'd1;
      state_d = (TRAIN_LEN == 1) ? ST_IDLE : ST_TRAIN;
    end else
`endif
    if (!empty) begin
      pop     = 1'b1;
      word_d  = head;
      act_d   = 1'b1;
      state_d = ST_DATA;
    end else begin
      und_d   = (state_q == ST_DATA);
      state_d = ST_IDLE;
    end
  end

  // state and output word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      word_q    <= IDLE_WORD;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      tx_active <= act_d;
      underrun  <= und_d;
    end
  end

`ifdef LVDS_TX_TRAIN_EN
  // training counter and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      trn_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      trn_q <= trn_d;
    end
  end
  assign training = trn_q;
`else
  assign training = 1'b0;
`endif

  assign tx_rise = lane_rise(word_q);
  assign tx_fall = lane_fall(word_q);

endmodule

// File: doc/lvds_tx_serializer.md
LVDS_TX_SERIALIZER -- requirements
Module: lvds_tx_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input word buffer depth; power of two, minimum 2.
REQ-002 Parameter TRAIN_LEN, default 64, number of training words sent per training burst; range 1..65535.
REQ-003 Parameter TRAIN_WORD, default 16'hA5C3, word transmitted during training.
REQ-004 Parameter IDLE_WORD, default 16'h0000, word transmitted when no data is available.
REQ-005 clk  in  1  single clock, one 16-bit word per cycle; the same clock is forwarded as the LVDS clock.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 s_data  in  16  word to transmit, ADC_data bit order.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  buffer can accept a word.
REQ-010 train_req  in  1  single-cycle request for a training burst.
REQ-011 tx_rise  out  8  lane bits for the rising-edge half of the DDR output.
REQ-012 tx_fall  out  8  lane bits for the falling-edge half of the DDR output.
REQ-013 tx_active  out  1  high while the current output word is buffered data.
REQ-014 training  out  1  high while the current output word is TRAIN_WORD.
REQ-015 underrun  out  1  one-cycle pulse when data streaming stops because the buffer is empty.

Function
REQ-016 Lane mapping: for word W and lanes i=0..7, tx_rise[i]=W[2i+1] and tx_fall[i]=W[2i]; a matching receiver recovers W exactly.
REQ-017 A word is accepted when s_valid and s_ready are both high at a rising clk edge; s_ready = buffer not full, computed combinationally from the occupancy count.
REQ-018 When the buffer is full, s_ready is low. A word is never accepted in a cycle where the buffer was full at the start of that cycle, even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop on a non-full buffer leaves occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 Output words are registered. If no training burst intervenes, a word accepted at edge N into an empty buffer appears on tx_rise/tx_fall in the cycle after edge N+1.
REQ-021 FSM states are TRAIN, IDLE and DATA. The FSM pops exactly one word per cycle in DATA and pops nothing in TRAIN or IDLE.
REQ-022 IDLE: output IDLE_WORD. The FSM moves to DATA when the buffer is non-empty; that transition cycle pops the first word.
REQ-023 DATA: output the popped word. If the buffer is empty, output IDLE_WORD, pulse underrun for that cycle and return to IDLE.
REQ-024 TRAIN: output TRAIN_WORD for exactly TRAIN_LEN consecutive cycles, then go to IDLE. The buffer keeps accepting words during TRAIN.
REQ-025 train_req seen in IDLE or DATA moves the FSM to TRAIN on the next edge and takes priority over a pop in the same cycle; no word is lost.
REQ-026 train_req seen during TRAIN is ignored; the count is not restarted.
REQ-027 tx_active and training are registered together with the output word and match it cycle for cycle.

Reset
REQ-028 While rst_n is low: tx_rise=IDLE_WORD odd bits, tx_fall=IDLE_WORD even bits, tx_active=0, training=0, underrun=0, s_ready=0, buffer empty, training counter cleared.
REQ-029 After rst_n is released, s_ready goes high on the first edge. Reset mid-stream discards all buffered words.

Configuration
REQ-030 Macro LVDS_TX_TRAIN_EN defined: the FSM enters TRAIN on the first edge after reset release, and train_req is honoured.
REQ-031 Macro LVDS_TX_TRAIN_EN undefined: the TRAIN state and its counter are absent, the FSM leaves reset into IDLE, train_req is ignored, and training is tied to 0.

Structure
REQ-032 A shared package lvds_pkg holds the FSM state enum typedef, the lane count constant (8) and the word width constant (16).
REQ-033 The buffer is the sub-module lvds_tx_fifo (synchronous FIFO: push/pop/full/empty/count). The FSM, lane mapping and output registers live in lvds_tx_serializer.

Verification
REQ-034 Reset release with LVDS_TX_TRAIN_EN defined, TRAIN_LEN=64 -> training high and words equal to 16'hA5C3 for exactly 64 cycles, then IDLE_WORD.
REQ-035 Push 16'h8001 into an empty buffer in IDLE -> tx_rise=8'h80 and tx_fall=8'h01 two cycles later, with tx_active high for one cycle and underrun pulsing on the following cycle.
REQ-036 Hold s_valid high with 16'h0000..16'h00FF while an 8-cycle train_req burst is active -> no word is lost, dropped or reordered; s_ready falls while the FIFO is full and rises when it drains.
REQ-037 Assert train_req mid-stream -> TRAIN_WORD is output from the next cycle, and the remaining words resume in order after TRAIN_LEN cycles.
REQ-038 Deassert rst_n asynchronously with 3 words buffered -> outputs reach reset values before the next edge, and no stale word appears after restart.
